aftab_serial_sign_restore: RTL and testbench

- Multi-cycle sign-restoration unit on the result path of the AFTAB multiplier/divider.
- The arithmetic core works on operand magnitudes. This block takes the unsigned quotient/remainder magnitudes plus sign-request flags and returns two's-complement results.
- It works bit-serially, LSB first, using the "copy up to and including the first 1, then invert" rule. One bit of each operand is handled per clock.
- It replaces a wide combinational negator with a small shift datapath and a start/done handshake toward the controller.

---
 rtl/aftab_serial_sign_restore.sv | 137 +++++++++++++
 tb/tb_aftab_serial_sign_restore.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_serial_sign_restore.sv
// Bit-serial sign restoration for the AFTAB multiplier/divider result path.
// Turns unsigned quotient/remainder magnitudes into two's-complement words, one bit per clock.
module aftab_serial_sign_restore #(
    parameter int size = 33
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            negQ,
    input  logic            negR,
    input  logic [size-1:0] quotientIn,
    input  logic [size-1:0] remainderIn,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] quotientOut,
    output logic [size-1:0] remainderOut,
    output logic            overflow
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [size-1:0] r_sq;
    logic [size-1:0] r_sr;
    logic            r_negQ;
    logic            r_negR;
    logic            r_seenQ;
    logic            r_seenR;
    logic [CW-1:0]   r_count;
    logic            r_pendOvf;

    logic            w_oQ;
    logic            w_oR;
    logic [size-1:0] w_sqNext;
    logic [size-1:0] w_srNext;
    logic            w_lastBit;
    logic            w_capOvf;

    // A positive result must fit below 2^(size-1); a negative one may reach exactly -2^(size-1).
    function automatic logic ovf(input logic [size-1:0] m, input logic n);
        return m[size-1] & (~n | (|m[size-2:0]));
    endfunction

    assign w_oQ      = r_negQ ? (r_sq[0] ^ r_seenQ) : r_sq[0];
    assign w_oR      = r_negR ? (r_sr[0] ^ r_seenR) : r_sr[0];
    assign w_sqNext  = {w_oQ, r_sq[size-1:1]};
    assign w_srNext  = {w_oR, r_sr[size-1:1]};
    assign w_lastBit = (r_count == CW'(size - 1));
    assign w_capOvf  = ovf(quotientIn, negQ) | ovf(remainderIn, negR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Results are published from the final shifted value so they land on the same edge as the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq         <= '0;
            r_sr         <= '0;
            r_negQ       <= 1'b0;
            r_negR       <= 1'b0;
            r_seenQ      <= 1'b0;
            r_seenR      <= 1'b0;
            r_count      <= '0;
            r_pendOvf    <= 1'b0;
            quotientOut  <= '0;
            remainderOut <= '0;
            overflow     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sq      <= quotientIn;
                        r_sr      <= remainderIn;
                        r_negQ    <= negQ;
                        r_negR    <= negR;
                        r_seenQ   <= 1'b0;
                        r_seenR   <= 1'b0;
                        r_count   <= '0;
                        r_pendOvf <= w_capOvf;
                    end
                end
                SHIFT: begin
                    r_sq    <= w_sqNext;
                    r_sr    <= w_srNext;
                    r_seenQ <= r_seenQ | r_sq[0];
                    r_seenR <= r_seenR | r_sr[0];
                    r_count <= r_count + CW'(1);
                    if (w_lastBit) begin
                        quotientOut  <= w_sqNext;
                        remainderOut <= w_srNext;
                        overflow     <= r_pendOvf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_serial_sign_restore.sv
// Randomized self-checking bench for aftab_serial_sign_restore at size 33 and size 8,
// compared against a plain-arithmetic negate-and-range-check reference model.
module tb_aftab_serial_sign_restore;

    logic        clk;
    logic        rst;

    logic        startA, negQA, negRA, busyA, doneA, ovfA;
    logic [32:0] qInA, rInA, qOutA, rOutA;

    logic        startB, negQB, negRB, busyB, doneB, ovfB;
    logic [7:0]  qInB, rInB, qOutB, rOutB;

    int          vecs;
    int          miss;
    logic [63:0] prevQ [2];
    logic [63:0] prevR [2];
    logic        prevO [2];

    aftab_serial_sign_restore #(.size(33)) dutA (
        .clk(clk), .rst(rst), .start(startA), .negQ(negQA), .negR(negRA),
        .quotientIn(qInA), .remainderIn(rInA), .busy(busyA), .done(doneA),
        .quotientOut(qOutA), .remainderOut(rOutA), .overflow(ovfA)
    );

    aftab_serial_sign_restore #(.size(8)) dutB (
        .clk(clk), .rst(rst), .start(startB), .negQ(negQB), .negR(negRB),
        .quotientIn(qInB), .remainderIn(rInB), .busy(busyB), .done(doneB),
        .quotientOut(qOutB), .remainderOut(rOutB), .overflow(ovfB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        if (obs !== exp) begin
            miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] maskOf(input int sz);
        return (64'd1 << sz) - 64'd1;
    endfunction

    // Signed result is simply the magnitude, negated when asked, reduced modulo 2^size.
    function automatic logic [63:0] refVal(input logic [63:0] m, input logic n, input int sz);
        return n ? ((64'd0 - m) & maskOf(sz)) : (m & maskOf(sz));
    endfunction

    // Representable range is -2^(size-1) .. 2^(size-1)-1.
    function automatic logic refOvf(input logic [63:0] m, input logic n, input int sz);
        logic [63:0] half;
        half = 64'd1 << (sz - 1);
        return n ? (m > half) : (m >= half);
    endfunction

    task automatic applyStimulus(input int which, input logic [63:0] q, input logic [63:0] r,
                                 input logic nq, input logic nr, input logic st);
        if (which == 0) begin
            qInA = q[32:0]; rInA = r[32:0]; negQA = nq; negRA = nr; startA = st;
        end else begin
            qInB = q[7:0];  rInB = r[7:0];  negQB = nq; negRB = nr; startB = st;
        end
    endtask

    task automatic readOut(input int which, output logic d, output logic b,
                           output logic [63:0] qo, output logic [63:0] ro, output logic ov);
        if (which == 0) begin
            d = doneA; b = busyA; qo = {31'd0, qOutA}; ro = {31'd0, rOutA}; ov = ovfA;
        end else begin
            d = doneB; b = busyB; qo = {56'd0, qOutB}; ro = {56'd0, rOutB}; ov = ovfB;
        end
    endtask

    // Caller must be at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic runOp(input int which, input logic [63:0] q, input logic [63:0] r,
                         input logic nq, input logic nr, input bit disturb,
                         output logic [63:0] qo, output logic [63:0] ro, output logic ov);
        int          sz;
        int          n;
        logic        d, b;
        logic [63:0] eq, er;
        logic        eo;
        sz = (which == 0) ? 33 : 8;
        eq = refVal(q, nq, sz);
        er = refVal(r, nr, sz);
        eo = refOvf(q, nq, sz) | refOvf(r, nr, sz);
        applyStimulus(which, q, r, nq, nr, 1'b1);
        @(negedge clk);
        applyStimulus(which, ~q, ~r, ~nq, ~nr, 1'b0);
        n = 0;
        forever begin
            readOut(which, d, b, qo, ro, ov);
            if (d || n >= sz + 20) break;
            if (n == sz / 2) begin
                checkOutput("holdQ", qo, prevQ[which]);
                checkOutput("holdR", ro, prevR[which]);
                checkOutput("holdOvf", {63'd0, ov}, {63'd0, prevO[which]});
                checkOutput("busyShift", {63'd0, b}, 64'd1);
            end
            if (disturb && n == 5) applyStimulus(which, q ^ 64'h5A5A, r ^ 64'h3C3C, ~nq, ~nr, 1'b1);
            else if (disturb && n == 6) applyStimulus(which, q, r, nq, nr, 1'b0);
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 64'(n), 64'(sz));
        if (!d) return;
        checkOutput("quotient", qo, eq);
        checkOutput("remainder", ro, er);
        checkOutput("overflow", {63'd0, ov}, {63'd0, eo});
        prevQ[which] = eq;
        prevR[which] = er;
        prevO[which] = eo;
        if (disturb) applyStimulus(which, ~q, r ^ 64'h1, ~nq, nr, 1'b1);
        @(negedge clk);
        applyStimulus(which, q, r, nq, nr, 1'b0);
        readOut(which, d, b, qo, ro, ov);
        checkOutput("doneAfter", {63'd0, d}, 64'd0);
        checkOutput("busyAfter", {63'd0, b}, 64'd0);
        if (disturb) begin
            @(negedge clk);
            readOut(which, d, b, qo, ro, ov);
            checkOutput("ignoredInDone", {62'd0, d, b}, 64'd0);
        end
    endtask

    task automatic randOperand(input int sz, output logic [63:0] m);
        logic [63:0] half;
        half = 64'd1 << (sz - 1);
        case ($urandom_range(0, 4))
            0: m = 64'd0;
            1: m = half;
            2: m = half | 64'd1;
            default: m = {$urandom, $urandom} & maskOf(sz);
        endcase
    endtask

    initial begin : main
        logic [63:0] qo, ro, q, r;
        logic        ov, d, b;
        int          doneSeen;
        vecs = 0;
        miss = 0;
        for (int i = 0; i < 2; i++) begin
            prevQ[i] = '0; prevR[i] = '0; prevO[i] = 1'b0;
        end
        rst = 1'b1;
        applyStimulus(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        #2;
        readOut(0, d, b, qo, ro, ov);
        checkOutput("resetA", {qo, ro} == 128'd0 ? {61'd0, d, b, ov} : 64'hBAD, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runOp(0, 64'd5, 64'd3, 1'b1, 1'b0, 1'b0, qo, ro, ov);
        checkOutput("dirQ5neg", qo, 64'h1_FFFF_FFFB);
        checkOutput("dirR3pos", ro, 64'd3);
        checkOutput("dirOvf0", {63'd0, ov}, 64'd0);

        runOp(0, 64'd0, 64'h1_0000_0000, 1'b1, 1'b1, 1'b0, qo, ro, ov);
        checkOutput("dirZeroNeg", qo, 64'd0);
        checkOutput("dirMinNeg", ro, 64'h1_0000_0000);
        checkOutput("dirMinOvf", {63'd0, ov}, 64'd0);

        runOp(0, 64'd0, 64'h1_0000_0000, 1'b1, 1'b0, 1'b0, qo, ro, ov);
        checkOutput("dirMinPos", ro, 64'h1_0000_0000);
        checkOutput("dirMinPosOvf", {63'd0, ov}, 64'd1);

        runOp(0, 64'h1_0000_0001, 64'd7, 1'b1, 1'b0, 1'b1, qo, ro, ov);
        checkOutput("dirBigNeg", qo, 64'h0_FFFF_FFFF);
        checkOutput("dirBigOvf", {63'd0, ov}, 64'd1);

        runOp(0, 64'd12, 64'd9, 1'b0, 1'b1, 1'b1, qo, ro, ov);
        checkOutput("dirB2bQ", qo, 64'd12);
        checkOutput("dirB2bR", ro, 64'h1_FFFF_FFF7);

        // Reset in the middle of an operation must discard it and clear outputs at once.
        applyStimulus(0, 64'd77, 64'd88, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        readOut(0, d, b, qo, ro, ov);
        checkOutput("rstQ", qo, 64'd0);
        checkOutput("rstR", ro, 64'd0);
        checkOutput("rstFlags", {61'd0, d, b, ov}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            prevQ[i] = '0; prevR[i] = '0; prevO[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (doneA) doneSeen++;
        end
        checkOutput("noDoneAfterRst", 64'(doneSeen), 64'd0);
        runOp(0, 64'd100, 64'd1, 1'b1, 1'b1, 1'b0, qo, ro, ov);
        checkOutput("postRstQ", qo, 64'h1_FFFF_FF9C);

        for (int i = 0; i < 1000; i++) begin
            randOperand(33, q);
            randOperand(33, r);
            runOp(0, q, r, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), qo, ro, ov);
        end
        for (int i = 0; i < 1000; i++) begin
            randOperand(8, q);
            randOperand(8, r);
            runOp(1, q, r, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), qo, ro, ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
